// File: rtl/match_event_recorder_if.sv
// Event readout channel: show-ahead head entry offered with a valid/ready handshake.
interface match_event_recorder_if #(
    parameter int unsigned TS_WIDTH = 16
);
    logic                evt_valid;
    logic                evt_ready;
    logic [TS_WIDTH-1:0] evt_timestamp;

    modport master (output evt_valid, output evt_timestamp, input evt_ready);
    modport slave  (input evt_valid, input evt_timestamp, output evt_ready);
endinterface

// File: rtl/match_event_recorder.sv
// Timestamps 101-detector matches into a show-ahead FIFO, with a saturating
// match counter and a sticky overflow flag for matches dropped on a full FIFO.
module match_event_recorder #(
    parameter int unsigned TS_WIDTH  = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sequence_detected,
    input  logic                     enable,
    input  logic                     clear,
    match_event_recorder_if.master   evt,
    output logic [$clog2(DEPTH):0]   evt_level,
    output logic [CNT_WIDTH-1:0]     match_count,
    output logic                     overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [TS_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [TS_WIDTH-1:0] ts;
    logic                valid_q;

    logic                rec_event;
    logic                full;
    logic                push;
    logic                pop;
    logic                drop;
    logic [LVL_W-1:0]    level_next;

    // Head is read straight from storage so nothing from the detector reaches outputs combinationally.
    assign evt.evt_valid     = valid_q;
    assign evt.evt_timestamp = mem[rd_ptr];

    // Handshake decode and next occupancy.
    always_comb begin
        rec_event  = sequence_detected & enable;
        pop        = valid_q & evt.evt_ready;
        full       = (evt_level == LVL_W'(DEPTH));
        push       = rec_event & (~full | pop);
        drop       = rec_event & full & ~pop;
        level_next = evt_level;
        if (push && !pop) begin
            level_next = evt_level + LVL_W'(1);
        end else if (pop && !push) begin
            level_next = evt_level - LVL_W'(1);
        end
    end

    // Storage is cleared too so the head reads zero after reset or clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= ts;
        end
    end

    // Pointers, occupancy, timestamp, counter and overflow; clear outranks everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            evt_level   <= '0;
            valid_q     <= 1'b0;
            ts          <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            evt_level   <= '0;
            valid_q     <= 1'b0;
            ts          <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            evt_level <= level_next;
            valid_q   <= (level_next != '0);
            if (enable) ts <= ts + TS_WIDTH'(1);
            if (rec_event && (match_count != {CNT_WIDTH{1'b1}})) begin
                match_count <= match_count + CNT_WIDTH'(1);
            end
            if (drop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_match_event_recorder.sv
// Directed bench for match_event_recorder: default instance plus a narrow
// instance for counter saturation and timestamp wrap.
module tb_match_event_recorder;
    logic clk = 1'b0;
    logic reset;
    logic sd, en, clr;
    logic sm_sd, sm_en, sm_clr;
    logic [2:0]  level;
    logic [7:0]  count;
    logic        ovf;
    logic [2:0]  sm_level;
    logic [3:0]  sm_count;
    logic        sm_ovf;
    logic [15:0] ts_m;
    int errors = 0;
    int checks = 0;

    match_event_recorder_if #(.TS_WIDTH(16)) ev_if ();
    match_event_recorder_if #(.TS_WIDTH(4))  sm_if ();

    match_event_recorder #(.TS_WIDTH(16), .DEPTH(4), .CNT_WIDTH(8)) u_dut (
        .clk(clk), .reset(reset), .sequence_detected(sd), .enable(en), .clear(clr),
        .evt(ev_if), .evt_level(level), .match_count(count), .overflow(ovf)
    );

    match_event_recorder #(.TS_WIDTH(4), .DEPTH(4), .CNT_WIDTH(4)) u_small (
        .clk(clk), .reset(reset), .sequence_detected(sm_sd), .enable(sm_en), .clear(sm_clr),
        .evt(sm_if), .evt_level(sm_level), .match_count(sm_count), .overflow(sm_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; tracks the main instance's timestamp from its current inputs.
    task automatic step();
        if (clr) ts_m = '0;
        else if (en) ts_m = ts_m + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic advance_to(input logic [15:0] target);
        while (ts_m != target) step();
    endtask

    initial begin
        reset = 1'b1; sd = 0; en = 1; clr = 0;
        sm_sd = 0; sm_en = 0; sm_clr = 0;
        ev_if.evt_ready = 0; sm_if.evt_ready = 0;
        ts_m = '0;
        #3;
        check_eq("rst_valid", 32'(ev_if.evt_valid), 0);
        check_eq("rst_ts", 32'(ev_if.evt_timestamp), 0);
        check_eq("rst_level", 32'(level), 0);
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_ovf", 32'(ovf), 0);
        #9 reset = 1'b0;

        // Single event at stamp 5, then one pop.
        advance_to(16'd5);
        sd = 1; step(); sd = 0;
        check_eq("single_valid", 32'(ev_if.evt_valid), 1);
        check_eq("single_ts", 32'(ev_if.evt_timestamp), 5);
        check_eq("single_level", 32'(level), 1);
        check_eq("single_count", 32'(count), 1);
        ev_if.evt_ready = 1; step(); ev_if.evt_ready = 0;
        check_eq("single_pop_valid", 32'(ev_if.evt_valid), 0);
        check_eq("single_pop_level", 32'(level), 0);

        // Backpressure: six events 10..15 into a 4-deep FIFO.
        clr = 1; step(); clr = 0;
        advance_to(16'd10);
        sd = 1;
        repeat (6) step();
        sd = 0;
        check_eq("bp_level", 32'(level), 4);
        check_eq("bp_ovf", 32'(ovf), 1);
        check_eq("bp_count", 32'(count), 6);
        ev_if.evt_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_drain", 32'(ev_if.evt_timestamp), 32'(10 + i));
            step();
        end
        ev_if.evt_ready = 0;
        check_eq("bp_empty", 32'(ev_if.evt_valid), 0);
        check_eq("bp_ovf_sticky", 32'(ovf), 1);

        // Full FIFO with a simultaneous pop accepts the new event.
        clr = 1; step(); clr = 0;
        check_eq("clr_ovf", 32'(ovf), 0);
        advance_to(16'd20);
        sd = 1;
        repeat (4) step();
        sd = 0;
        check_eq("full_level", 32'(level), 4);
        advance_to(16'd30);
        sd = 1; ev_if.evt_ready = 1; step(); sd = 0; ev_if.evt_ready = 0;
        check_eq("fp_ovf", 32'(ovf), 0);
        check_eq("fp_level", 32'(level), 4);
        check_eq("fp_count", 32'(count), 5);
        ev_if.evt_ready = 1;
        check_eq("fp_drain0", 32'(ev_if.evt_timestamp), 21); step();
        check_eq("fp_drain1", 32'(ev_if.evt_timestamp), 22); step();
        check_eq("fp_drain2", 32'(ev_if.evt_timestamp), 23); step();
        check_eq("fp_drain3", 32'(ev_if.evt_timestamp), 30); step();
        ev_if.evt_ready = 0;
        check_eq("fp_empty", 32'(ev_if.evt_valid), 0);

        // Clear colliding with an event at level 2 with overflow set.
        clr = 1; step(); clr = 0;
        sd = 1; repeat (5) step(); sd = 0;
        ev_if.evt_ready = 1; repeat (2) step(); ev_if.evt_ready = 0;
        check_eq("pre_clr_level", 32'(level), 2);
        check_eq("pre_clr_ovf", 32'(ovf), 1);
        check_eq("pre_clr_count", 32'(count), 5);
        clr = 1; sd = 1; step(); clr = 0; sd = 0;
        check_eq("clr_level", 32'(level), 0);
        check_eq("clr_count", 32'(count), 0);
        check_eq("clr_ovf2", 32'(ovf), 0);
        check_eq("clr_valid", 32'(ev_if.evt_valid), 0);
        check_eq("clr_head", 32'(ev_if.evt_timestamp), 0);
        repeat (3) step();
        sd = 1; repeat (2) step(); sd = 0;
        check_eq("clr_ts_restart", 32'(ev_if.evt_timestamp), 3);
        check_eq("clr_level2", 32'(level), 2);

        // Enable low: pulses ignored, timestamp frozen, FIFO still drains.
        en = 0; sd = 1;
        repeat (5) step();
        check_eq("dis_level", 32'(level), 2);
        check_eq("dis_count", 32'(count), 2);
        ev_if.evt_ready = 1;
        check_eq("dis_head0", 32'(ev_if.evt_timestamp), 3); step();
        check_eq("dis_head1", 32'(ev_if.evt_timestamp), 4);
        check_eq("dis_level1", 32'(level), 1);
        step();
        ev_if.evt_ready = 0;
        check_eq("dis_empty", 32'(ev_if.evt_valid), 0);
        en = 1; step(); sd = 0;
        check_eq("dis_frozen_ts", 32'(ev_if.evt_timestamp), 5);
        check_eq("dis_count2", 32'(count), 3);

        // Asynchronous reset between edges while draining.
        sd = 1; repeat (2) step(); sd = 0;
        ev_if.evt_ready = 1; step();
        #2 reset = 1'b1;
        #1;
        check_eq("arst_valid", 32'(ev_if.evt_valid), 0);
        check_eq("arst_ts", 32'(ev_if.evt_timestamp), 0);
        check_eq("arst_level", 32'(level), 0);
        check_eq("arst_count", 32'(count), 0);
        ev_if.evt_ready = 0;
        sm_en = 1;
        #2 reset = 1'b0;
        ts_m = '0;

        // Narrow instance: 4-bit timestamp wraps, 4-bit counter saturates.
        repeat (17) step();
        sm_sd = 1; step();
        check_eq("wrap_ts", 32'(sm_if.evt_timestamp), 1);
        check_eq("wrap_count", 32'(sm_count), 1);
        repeat (13) step();
        check_eq("sat_edge", 32'(sm_count), 14);
        step();
        check_eq("sat_max", 32'(sm_count), 15);
        repeat (5) step();
        sm_sd = 0;
        check_eq("sat_hold", 32'(sm_count), 15);
        check_eq("sat_level", 32'(sm_level), 4);
        check_eq("sat_ovf", 32'(sm_ovf), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
